// File: rtl/reg_file_shadow_pkg.sv
// Shared definitions for the shadowed register file.
//   WIDTH_DEF / DEPTH_DEF : default register width and register count
//   op_e                  : {save, restore} operation encoding
//   cell_sel_e            : next-value source for a loaded register cell
package reg_file_shadow_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF = 8;

    // Bit 1 is save, bit 0 is restore.
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_RESTORE = 2'b01,
        OP_SAVE    = 2'b10,
        OP_SWAP    = 2'b11
    } op_e;

    typedef enum logic {
        CELL_SEL_WDATA  = 1'b0,
        CELL_SEL_SHADOW = 1'b1
    } cell_sel_e;

endpackage

// File: rtl/reg_file_shadow_cell.sv
// One WIDTH-bit load-enabled register with synchronous active-low reset.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : capture a new value at the edge (otherwise hold)
//   sel_i         : new value source, wdata_i or shadow_i
//   wdata_i       : write-port data
//   shadow_i      : value from the opposite bank
//   q_o           : stored value
module reg_cell
    import reg_file_shadow_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  cell_sel_e        sel_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] shadow_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next value: hold unless loaded, then pick the selected source.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = (sel_i == CELL_SEL_SHADOW) ? shadow_i : wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg_file_shadow.sv
// Register bank with one write port, two combinational read ports and a
// shadow bank supporting single-edge save, restore and swap.
//   clock, resetn      : clock, synchronous active-low reset
//   write/waddr/wdata  : write port (out-of-range waddr is ignored)
//   raddr_a/raddr_b    : read addresses; rdata_a/rdata_b combinational
//   save/restore       : shadow operations, both high = swap
//   shadow_valid       : shadow bank holds a saved context
//   dirty              : per-register written-since-last-save/restore mask
module reg_file_shadow
    import reg_file_shadow_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             write,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             save,
    input  logic             restore,
    output logic             shadow_valid,
    output logic [DEPTH-1:0] dirty
);

    logic [WIDTH-1:0] live_q   [DEPTH];
    logic [WIDTH-1:0] shadow_q [DEPTH];
    logic [DEPTH-1:0] live_load;
    cell_sel_e        live_sel [DEPTH];

    logic [DEPTH-1:0] wr_hit;
    logic             save_en;
    logic             restore_en;
    logic             clr_dirty;
    op_e              op;

    logic             shadow_valid_d;
    logic             shadow_valid_q;
    logic [DEPTH-1:0] dirty_d;
    logic [DEPTH-1:0] dirty_q;

    assign op = op_e'({save, restore});

    // One-hot write decode; addresses >= DEPTH match no entry.
    always_comb begin
        wr_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr_hit[i] = write && (waddr == AW'(i));
        end
    end

    // Shadow operation decode; a swap or restore with no saved context
    // degrades to save / no-op respectively.
    always_comb begin
        save_en        = 1'b0;
        restore_en     = 1'b0;
        clr_dirty      = 1'b0;
        shadow_valid_d = shadow_valid_q;
        unique case (op)
            OP_SAVE: begin
                save_en        = 1'b1;
                clr_dirty      = 1'b1;
                shadow_valid_d = 1'b1;
            end
            OP_RESTORE: begin
                if (shadow_valid_q) begin
                    restore_en     = 1'b1;
                    clr_dirty      = 1'b1;
                    shadow_valid_d = 1'b0;
                end
            end
            OP_SWAP: begin
                save_en        = 1'b1;
                restore_en     = shadow_valid_q;
                clr_dirty      = 1'b1;
                shadow_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // A same-cycle write overrides the restored value for its entry.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            live_load[i] = wr_hit[i] || restore_en;
            live_sel[i]  = wr_hit[i] ? CELL_SEL_WDATA : CELL_SEL_SHADOW;
        end
    end

    assign dirty_d = (clr_dirty ? '0 : dirty_q) | wr_hit;

    for (genvar g = 0; g < DEPTH; g++) begin : g_bank
        reg_cell #(.WIDTH(WIDTH)) u_live (
            .clk_i    (clock),
            .rst_ni   (resetn),
            .load_i   (live_load[g]),
            .sel_i    (live_sel[g]),
            .wdata_i  (wdata),
            .shadow_i (shadow_q[g]),
            .q_o      (live_q[g])
        );

        // Shadow entries only ever load from the pre-edge live value.
        reg_cell #(.WIDTH(WIDTH)) u_shadow (
            .clk_i    (clock),
            .rst_ni   (resetn),
            .load_i   (save_en),
            .sel_i    (CELL_SEL_SHADOW),
            .wdata_i  (live_q[g]),
            .shadow_i (live_q[g]),
            .q_o      (shadow_q[g])
        );
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            shadow_valid_q <= 1'b0;
            dirty_q        <= '0;
        end else begin
            shadow_valid_q <= shadow_valid_d;
            dirty_q        <= dirty_d;
        end
    end

    // Read ports: stored value, optional same-cycle forwarding, 0 out of range.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) begin
                rdata_a = (BYPASS && wr_hit[i]) ? wdata : live_q[i];
            end
            if (raddr_b == AW'(i)) begin
                rdata_b = (BYPASS && wr_hit[i]) ? wdata : live_q[i];
            end
        end
    end

    assign shadow_valid = shadow_valid_q;
    assign dirty        = dirty_q;

endmodule
